// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the single-port instruction/data memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int STARVE_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select between fetch and data requesters, with a saturating
// starvation counter that forces a fetch win after repeated data grants.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic d_req,
    input  logic arb_en,
    output logic win_if,
    output logic win_d
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0] starve_cnt_reg;
    logic                starved;

    assign starved = if_req && (starve_cnt_reg == LIMIT);

    always_comb begin
        win_d  = arb_en && d_req && !starved;
        win_if = arb_en && if_req && !win_d;
    end

    // Only arbitration cycles move the counter; ISSUE/RESP leave it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_reg <= '0;
        end else if (arb_en) begin
            if (win_if || !if_req) begin
                starve_cnt_reg <= '0;
            end else if (win_d && (starve_cnt_reg != LIMIT)) begin
                starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one variable-latency memory port,
// one outstanding transaction at a time.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_t            state_reg;
    owner_t            owner_reg;
    logic              req_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              arb_en;
    logic              win_if;
    logic              win_d;
    logic              capture;
    logic              store_done;

    // Reset masks arbitration so no grant can pulse while the block is held.
    assign arb_en = (state_reg == IDLE) && !reset;

    mem_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk    (clk),
        .reset  (reset),
        .if_req (if_req),
        .d_req  (d_req),
        .arb_en (arb_en),
        .win_if (win_if),
        .win_d  (win_d)
    );

    assign if_gnt    = win_if;
    assign d_gnt     = win_d;
    assign mem_req   = req_reg;
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg & WORD_MASK;
    assign mem_wdata = wdata_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            owner_reg <= OWN_IF;
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (win_d || win_if) begin
                        state_reg <= ISSUE;
                        req_reg   <= 1'b1;
                        owner_reg <= win_d ? OWN_D : OWN_IF;
                        we_reg    <= win_d && d_we;
                        addr_reg  <= win_d ? d_addr : if_addr;
                        if (win_d) begin
                            wdata_reg <= d_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        req_reg   <= 1'b0;
                        state_reg <= we_reg ? IDLE : RESP;
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign capture    = (state_reg == RESP) && mem_rvalid;
    assign store_done = (state_reg == ISSUE) && mem_ready && we_reg;

    // One response register pair per requester; stores only ever belong to OWN_D.
    for (genvar gi = 0; gi < 2; gi++) begin : g_resp
        localparam owner_t MY_OWNER = (gi == 0) ? OWN_IF : OWN_D;

        logic [DATA_W-1:0] rdata_reg;
        logic              rvalid_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                rdata_reg  <= '0;
                rvalid_reg <= 1'b0;
            end else begin
                rvalid_reg <= (capture || store_done) && (owner_reg == MY_OWNER);
                if (capture && (owner_reg == MY_OWNER)) begin
                    rdata_reg <= mem_rdata;
                end
            end
        end

        if (MY_OWNER == OWN_IF) begin : g_if
            assign if_rdata  = rdata_reg;
            assign if_rvalid = rvalid_reg;
        end else begin : g_d
            assign d_rdata  = rdata_reg;
            assign d_rvalid = rvalid_reg;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Single-port memory arbiter for the multi-cycle RV32 core.
- Shares one unified instruction/data memory between the fetch requester (IF state) and the data requester (MEM state: loads and stores).
- Serialises transactions with exactly one outstanding access at a time, and handles a variable-latency memory handshake.
- Data requests have priority; an anti-starvation counter guarantees fetch progress.

Parameters:
ADDR_W, 32, address width of requester and memory ports
DATA_W, 32, data width
STARVE_LIMIT, 4, number of consecutive data grants while if_req is held before fetch is forced to win (range 1..15)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous active-high reset
if_req  input  1  fetch request; held until if_gnt
if_addr  input  ADDR_W  fetch byte address
if_gnt  output  1  one-cycle pulse: fetch request latched
if_rvalid  output  1  one-cycle pulse: if_rdata valid
if_rdata  output  DATA_W  fetched word, registered, holds until next fetch completes
d_req  input  1  data request; held until d_gnt
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data byte address
d_wdata  input  DATA_W  store data
d_gnt  output  1  one-cycle pulse: data request latched
d_rvalid  output  1  one-cycle pulse: load data valid or store complete
d_rdata  output  DATA_W  load word, registered; unchanged by stores
mem_req  output  1  memory command valid
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  word-aligned address ([1:0] forced 0)
mem_wdata  output  DATA_W  write data
mem_ready  input  1  memory accepts command this cycle
mem_rvalid  input  1  read data valid
mem_rdata  input  DATA_W  read data

Behaviour:
- State machine has three states: IDLE, ISSUE, RESP.
- Reset (synchronous, any state): state=IDLE. All of these clear to 0: mem_req, mem_we, mem_addr, mem_wdata, if_gnt, d_gnt, if_rvalid, d_rvalid, if_rdata, d_rdata, starve counter, owner. Any in-flight transaction is abandoned and produces no rvalid.
- IDLE, arbitration (combinational winner):
  - If d_req and not (if_req and starve_cnt==STARVE_LIMIT), data wins.
  - Otherwise, if if_req, fetch wins.
  - Otherwise, stay in IDLE.
- IDLE, on a win:
  - Pulse the winner's gnt combinationally in the same cycle.
  - Latch addr, we (forced 0 for fetch), wdata and owner.
  - Next state is ISSUE.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, on a data win while if_req=1.
  - Clears on a fetch win, or on any IDLE cycle with if_req=0.
- ISSUE:
  - mem_req=1, driven from the latched fields.
  - While mem_ready=0, hold all fields stable indefinitely.
  - On mem_ready=1 with a store: next state IDLE, d_rvalid pulses in the next cycle.
  - On mem_ready=1 with a load or fetch: next state RESP.
- RESP:
  - mem_req=0. Wait for mem_rvalid.
  - On mem_rvalid, capture mem_rdata into the owner's rdata register. The owner's rvalid pulses in the next cycle (the IDLE cycle).
  - Next state is IDLE.
- mem_rvalid is ignored in IDLE and ISSUE. The earliest legal response is the cycle after acceptance.
- Minimum latency, gnt to rvalid:
  - Load/fetch with zero-wait memory: gnt in cycle 0, ISSUE in cycle 1, RESP with rvalid in cycle 2, rvalid pulse in cycle 3.
  - Store: rvalid pulse in cycle 2.
- A new grant may occur in the same IDLE cycle as the previous rvalid pulse.
- Simultaneous if_req and d_req: resolved by the priority rule above. The loser keeps its req held and is not acknowledged.
- A requester deasserting req before gnt: the request is simply dropped; no error.
- rdata registers hold their value until overwritten by their own owner's next read.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum (IDLE, ISSUE, RESP)
  - owner encoding (OWN_IF=0, OWN_D=1)
  - opcode-independent constants ADDR_W and DATA_W defaults
- Sub-module mem_arb_prio: the winner select plus the saturating starve counter, with inputs if_req, d_req, arb_en and outputs win_if, win_d.
- The FSM, field latches and response registers stay in the top module.

Test Plan:
- Fetch read, zero-wait: if_req=1 with if_addr=0x10; mem_ready=1 in ISSUE; mem_rvalid=1 with mem_rdata=0x00500093 in RESP. Expect if_gnt in cycle 0, mem_addr=0x10, and if_rvalid in cycle 3 with if_rdata=0x00500093. d_rdata stays 0.
- Store with wait states: d_req=1, d_we=1, d_addr=0x107 (sent as 0x104), d_wdata=0xDEADBEEF; mem_ready low for 3 cycles. Expect mem_req, addr and data held stable for 4 cycles, and d_rvalid one cycle after acceptance. d_rdata unchanged.
- Simultaneous requests: if_req and d_req both held, STARVE_LIMIT=4, stores accepted immediately. Expect 4 data grants, then a fetch grant, then the counter clears.
- Back-to-back: load completes and a new if_req is present. Expect if_gnt in the same cycle as the d_rvalid pulse.
- Early or stray mem_rvalid: mem_rvalid=1 while in ISSUE, or in IDLE with 0xFFFFFFFF. Expect it ignored: no rvalid and no rdata change.
- Reset mid-read: assert reset in RESP. Expect IDLE, mem_req=0, and all rdata=0 next cycle. A late mem_rvalid after reset yields no if_rvalid or d_rvalid.
